// File: rtl/hazard_ctrl.sv
// Load-use stall and branch/jump flush controller for the 5-stage MIPS pipeline.
// Optional saturating stall/flush statistics are built when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IDEX_MemRead,
  input  logic [31:0] IDEX_Instruction,
  input  logic [31:0] IFID_Instruction,
  input  logic        Branch_Taken,
  input  logic        Jump,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEX_Flush,
  output logic        IFID_Flush,
  output logic        Stall_Active,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  if (LOAD_STALL_CYCLES == 0 || LOAD_STALL_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_param
    $error("hazard_ctrl: LOAD_STALL_CYCLES must be 1..2**CNT_W-1");
  end

  typedef enum logic {RUN, LSTALL} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [4:0] ex_rt, id_rs, id_rt;
  logic       lu_hazard, redirect;
  logic       unused_bits;

  assign ex_rt = IDEX_Instruction[20:16];
  assign id_rs = IFID_Instruction[25:21];
  assign id_rt = IFID_Instruction[20:16];
  assign unused_bits = ^{IDEX_Instruction[31:21], IDEX_Instruction[15:0],
                         IFID_Instruction[31:26], IFID_Instruction[15:0]};

  // id_rt is compared even for I-type consumers, trading an occasional spurious bubble for no decode
  assign lu_hazard = IDEX_MemRead && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign redirect  = Branch_Taken || Jump;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (lu_hazard && (LOAD_STALL_CYCLES > 1)) begin
          state_next = LSTALL;
          cnt_next   = CNT_W'(LOAD_STALL_CYCLES - 2);
        end
      end
      LSTALL: begin
        if (cnt == '0) state_next = RUN;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // Mealy outputs: the first stall cycle is decided in RUN from the live hazard compare
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEX_Flush = 1'b0;
    IFID_Flush = 1'b0;
    if (!Reset) begin
      case (state)
        RUN: begin
          if (lu_hazard) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEX_Flush = 1'b1;
          end else if (redirect) begin
            IFID_Flush = 1'b1;
          end
        end
        LSTALL: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEX_Flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Stall_Active = ~PCWrite;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_Active && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (IFID_Flush && (flush_cnt_q != 16'hFFFF))   flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  assign StallCycles = 16'h0000;
  assign FlushCount  = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (1, 3 and 4 stall cycles) share one stimulus stream.
// Statistics expectations follow HAZARD_STATS_EN when it is defined for the build.
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [31:0] LW_R8   = 32'h8D28_0000; // lw  $8,0($9)
  localparam logic [31:0] LW_R0   = 32'h8D20_0000; // lw  $0,0($9)
  localparam logic [31:0] ADD_RS8 = 32'h010B_5020; // add $10,$8,$11
  localparam logic [31:0] ADD_RT8 = 32'h0168_5020; // add $10,$11,$8
  localparam logic [31:0] ADD_NO8 = 32'h012B_5020; // add $10,$9,$11
  localparam logic [31:0] ADD_R0  = 32'h0000_5020; // add $10,$0,$0

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IDEX_MemRead;
  logic [31:0] IDEX_Instruction, IFID_Instruction;
  logic        Branch_Taken, Jump;

  logic        pcw1, ifw1, idf1, iff1, sa1;
  logic        pcw3, ifw3, idf3, iff3, sa3;
  logic        pcw4, ifw4, idf4, iff4, sa4;
  logic [15:0] sc1, fc1, sc3, fc3, sc4, fc4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u1 (
    .Clock(Clock), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Instruction(IDEX_Instruction), .IFID_Instruction(IFID_Instruction),
    .Branch_Taken(Branch_Taken), .Jump(Jump),
    .PCWrite(pcw1), .IFIDWrite(ifw1), .IDEX_Flush(idf1), .IFID_Flush(iff1),
    .Stall_Active(sa1), .StallCycles(sc1), .FlushCount(fc1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u3 (
    .Clock(Clock), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Instruction(IDEX_Instruction), .IFID_Instruction(IFID_Instruction),
    .Branch_Taken(Branch_Taken), .Jump(Jump),
    .PCWrite(pcw3), .IFIDWrite(ifw3), .IDEX_Flush(idf3), .IFID_Flush(iff3),
    .Stall_Active(sa3), .StallCycles(sc3), .FlushCount(fc3));

  hazard_ctrl #(.LOAD_STALL_CYCLES(4), .CNT_W(4)) u4 (
    .Clock(Clock), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Instruction(IDEX_Instruction), .IFID_Instruction(IFID_Instruction),
    .Branch_Taken(Branch_Taken), .Jump(Jump),
    .PCWrite(pcw4), .IFIDWrite(ifw4), .IDEX_Flush(idf4), .IFID_Flush(iff4),
    .Stall_Active(sa4), .StallCycles(sc4), .FlushCount(fc4));

  // Apply one cycle of inputs just after the edge, then wait to the falling edge to sample.
  task automatic drive(input logic rst, input logic mr, input logic [31:0] exi,
                       input logic [31:0] idi, input logic br, input logic jp);
    @(posedge Clock);
    #1;
    Reset            = rst;
    IDEX_MemRead     = mr;
    IDEX_Instruction = exi;
    IFID_Instruction = idi;
    Branch_Taken     = br;
    Jump             = jp;
    @(negedge Clock);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, LW_R8, ADD_RS8, 1'b1, 1'b0);
    drive(1'b1, 1'b1, LW_R8, ADD_RS8, 1'b1, 1'b0);
    n_checks++;
    if ({pcw1, ifw1, idf1, iff1} !== 4'b1100) begin
      n_errors++; $display("FAIL reset_outputs: got %b required 1100", {pcw1, ifw1, idf1, iff1});
    end
    n_checks++;
    if ({pcw4, sa4} !== 2'b10) begin
      n_errors++; $display("FAIL reset_outputs_u4: got %b required 10", {pcw4, sa4});
    end
    idle();
    n_checks++;
    if ({sc1, fc1} !== 32'h0) begin
      n_errors++; $display("FAIL reset_counters: got %h required 00000000", {sc1, fc1});
    end
    n_checks++;
    if ({pcw1, sa1, iff1} !== 3'b100) begin
      n_errors++; $display("FAIL reset_idle: got %b required 100", {pcw1, sa1, iff1});
    end
  endtask

  task automatic test_basic_load_use();
    do_reset();
    drive(1'b0, 1'b1, LW_R8, ADD_RS8, 1'b0, 1'b0);
    n_checks++;
    if ({pcw1, ifw1, idf1, iff1, sa1} !== 5'b00101) begin
      n_errors++; $display("FAIL basic_stall: got %b required 00101", {pcw1, ifw1, idf1, iff1, sa1});
    end
    drive(1'b0, 1'b0, 32'h0, ADD_RS8, 1'b0, 1'b0);
    n_checks++;
    if ({pcw1, ifw1, idf1, iff1} !== 4'b1100) begin
      n_errors++; $display("FAIL basic_release: got %b required 1100", {pcw1, ifw1, idf1, iff1});
    end
    do_reset();
    drive(1'b0, 1'b1, LW_R8, ADD_RT8, 1'b0, 1'b0);
    n_checks++;
    if ({pcw1, idf1} !== 2'b01) begin
      n_errors++; $display("FAIL rt_match_stall: got %b required 01", {pcw1, idf1});
    end
    drive(1'b0, 1'b1, LW_R8, ADD_NO8, 1'b0, 1'b0);
    n_checks++;
    if ({pcw1, idf1} !== 2'b10) begin
      n_errors++; $display("FAIL no_match: got %b required 10", {pcw1, idf1});
    end
    drive(1'b0, 1'b0, LW_R8, ADD_RS8, 1'b0, 1'b0);
    n_checks++;
    if ({pcw1, idf1} !== 2'b10) begin
      n_errors++; $display("FAIL no_memread: got %b required 10", {pcw1, idf1});
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(1'b0, 1'b1, LW_R0, ADD_R0, 1'b0, 1'b0);
    n_checks++;
    if ({pcw1, pcw3, pcw4, idf1, idf3, idf4} !== 6'b111000) begin
      n_errors++; $display("FAIL reg_zero: got %b required 111000", {pcw1, pcw3, pcw4, idf1, idf3, idf4});
    end
  endtask

  task automatic test_multi_cycle();
    int stalls;
    do_reset();
    stalls = 0;
    drive(1'b0, 1'b1, LW_R8, ADD_RS8, 1'b0, 1'b0);
    if (pcw3 === 1'b0 && idf3 === 1'b1) stalls++;
    // a taken branch during LSTALL must not flush
    drive(1'b0, 1'b0, 32'h0, ADD_RS8, 1'b1, 1'b0);
    if (pcw3 === 1'b0 && idf3 === 1'b1) stalls++;
    n_checks++;
    if (iff3 !== 1'b0) begin
      n_errors++; $display("FAIL lstall_ignores_branch: got %b required 0", iff3);
    end
    drive(1'b0, 1'b0, 32'h0, ADD_RS8, 1'b0, 1'b0);
    if (pcw3 === 1'b0 && idf3 === 1'b1) stalls++;
    n_checks++;
    if (stalls != 3) begin
      n_errors++; $display("FAIL multi_stall_len: got %0d required 3", stalls);
    end
    idle();
    n_checks++;
    if ({pcw3, ifw3, idf3, sa3} !== 4'b1100) begin
      n_errors++; $display("FAIL multi_back_to_run: got %b required 1100", {pcw3, ifw3, idf3, sa3});
    end
    n_checks++;
    if (sc3 !== (STATS ? 16'd3 : 16'd0)) begin
      n_errors++; $display("FAIL multi_stall_count: got %0d required %0d", sc3, STATS ? 3 : 0);
    end
    n_checks++;
    if (fc3 !== 16'd0) begin
      n_errors++; $display("FAIL multi_flush_count: got %0d required 0", fc3);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b0, 1'b0, 32'h0, ADD_RS8, 1'b1, 1'b0);
    n_checks++;
    if ({pcw1, ifw1, idf1, iff1} !== 4'b1101) begin
      n_errors++; $display("FAIL branch_flush: got %b required 1101", {pcw1, ifw1, idf1, iff1});
    end
    drive(1'b0, 1'b0, 32'h0, ADD_RS8, 1'b0, 1'b1);
    n_checks++;
    if ({pcw1, iff1} !== 2'b11) begin
      n_errors++; $display("FAIL jump_flush: got %b required 11", {pcw1, iff1});
    end
    idle();
    n_checks++;
    if (iff1 !== 1'b0) begin
      n_errors++; $display("FAIL redirect_one_cycle: got %b required 0", iff1);
    end
    n_checks++;
    if (fc1 !== (STATS ? 16'd2 : 16'd0)) begin
      n_errors++; $display("FAIL flush_count: got %0d required %0d", fc1, STATS ? 2 : 0);
    end
    n_checks++;
    if (sc1 !== 16'd0) begin
      n_errors++; $display("FAIL redirect_stall_count: got %0d required 0", sc1);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1'b0, 1'b1, LW_R8, ADD_RS8, 1'b1, 1'b0);
    n_checks++;
    if ({pcw1, idf1, iff1} !== 3'b010) begin
      n_errors++; $display("FAIL simul_u1: got %b required 010", {pcw1, idf1, iff1});
    end
    n_checks++;
    if ({pcw4, idf4, iff4} !== 3'b010) begin
      n_errors++; $display("FAIL simul_u4: got %b required 010", {pcw4, idf4, iff4});
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b0, 1'b1, LW_R8, ADD_RS8, 1'b0, 1'b0);
    n_checks++;
    if (pcw4 !== 1'b0) begin
      n_errors++; $display("FAIL mid_first_stall: got %b required 0", pcw4);
    end
    drive(1'b1, 1'b0, 32'h0, ADD_RS8, 1'b0, 1'b0);
    n_checks++;
    if ({pcw4, ifw4, idf4, sa4} !== 4'b1100) begin
      n_errors++; $display("FAIL mid_reset_outputs: got %b required 1100", {pcw4, ifw4, idf4, sa4});
    end
    idle();
    n_checks++;
    if ({pcw4, idf4} !== 2'b10) begin
      n_errors++; $display("FAIL mid_after_reset_run: got %b required 10", {pcw4, idf4});
    end
    n_checks++;
    if ({sc4, fc4} !== 32'h0) begin
      n_errors++; $display("FAIL mid_counters: got %h required 00000000", {sc4, fc4});
    end
    // a fresh hazard after the abort must give the full four-cycle stall
    drive(1'b0, 1'b1, LW_R8, ADD_RS8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, ADD_RS8, 1'b0, 1'b0);
      n_checks++;
      if (pcw4 !== 1'b0) begin
        n_errors++; $display("FAIL fresh_stall_%0d: got %b required 0", i + 2, pcw4);
      end
    end
    idle();
    n_checks++;
    if (pcw4 !== 1'b1) begin
      n_errors++; $display("FAIL fresh_stall_end: got %b required 1", pcw4);
    end
  endtask

  initial begin
    Reset            = 1'b1;
    IDEX_MemRead     = 1'b0;
    IDEX_Instruction = 32'h0;
    IFID_Instruction = 32'h0;
    Branch_Taken     = 1'b0;
    Jump             = 1'b0;
    test_reset();
    test_basic_load_use();
    test_reg_zero();
    test_multi_cycle();
    test_redirect();
    test_simultaneous();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
